lane_deskew_align: RTL

//  N-lane CSI-2 byte-to-word aligner with per-lane skew compensation up to MAX_SKEW cycles.

---
 rtl/csi_align_pkg.sv | 38 +++
 rtl/lane_delay_line.sv | 42 ++++
 rtl/lane_deskew_align.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/csi_align_pkg.sv
// Shared types and helpers for the CSI-2 lane deskew aligner.
package csi_align_pkg;

    // Widest lane configuration this aligner supports.
    localparam int MAX_LANES = 4;

    // Aligner control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_STREAM = 2'd2
    } align_state_e;

    // Runtime lane-count selections; the reserved code behaves as 4 lanes.
    typedef enum logic [1:0] {
        CFG_1LANE = 2'd0,
        CFG_2LANE = 2'd1,
        CFG_4LANE = 2'd2,
        CFG_RSVD  = 2'd3
    } cfg_lanes_e;

    // Active-lane mask for a lane-count selection, clipped to the physical lane count.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] cfg, input int lanes);
        logic [MAX_LANES-1:0] want;
        logic [MAX_LANES-1:0] phys;
        case (cfg_lanes_e'(cfg))
            CFG_1LANE: want = 4'b0001;
            CFG_2LANE: want = 4'b0011;
            default:   want = 4'b1111;
        endcase
        phys = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) phys[i] = 1'b1;
        end
        return want & phys;
    endfunction

endpackage

// File: rtl/lane_delay_line.sv
// Per-lane byte history with a selectable tap: tap 0 is the current input,
// tap k is the byte seen k cycles ago.
module lane_delay_line
    import csi_align_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] din,
    input  logic [SW-1:0] tap,
    output logic [DW-1:0] dout
);

    // hist[k-1] holds the byte received k cycles ago.
    logic [DW-1:0] hist [DEPTH];

    // Shift history by one byte every cycle, independent of lane valid.
    // NOTE: this small history array is reset on purpose so a fresh packet never
    // sees stale bytes through a nonzero tap; large RAM-style storage would not be.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read the pre-edge
            // value of its neighbour, which is what turns this into a shift register.
            hist[0] <= din;
            for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
        end
    end

    // Tap mux; out-of-range taps fall back to the live input.
    always_comb begin
        dout = din;
        for (int k = 1; k <= DEPTH; k++) begin
            if (tap == SW'(k)) dout = hist[k-1];
        end
    end

endmodule

// File: rtl/lane_deskew_align.sv
// CSI-2 lane deskew aligner: measures each active lane's first-valid offset at
// packet start, delays early lanes to match the latest, then streams whole words.
module lane_deskew_align
    import csi_align_pkg::*;
#(
    parameter int  LANES    = 4,
    parameter int  DW       = 8,
    parameter int  MAX_SKEW = 3,
    localparam int SW       = $clog2(MAX_SKEW + 1)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [1:0]          cfg_lanes,
    input  logic                packet_done,
    input  logic [LANES*DW-1:0] byte_data,
    input  logic [LANES-1:0]    byte_valid,
    output logic [LANES*DW-1:0] word_data,
    output logic                word_valid,
    output logic                err_skew,
    output logic [LANES*SW-1:0] skew_tap
);

    align_state_e         state_q, state_d;
    logic [MAX_LANES-1:0] cfg_mask_full;
    logic [LANES-1:0]     cfg_mask, mask_q, cur_mask;
    logic                 valid_any, valid_any_q, start;
    logic [LANES-1:0]     arrived_q, arrived_d, new_lanes;
    logic [SW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [SW-1:0]        off_q   [LANES];
    logic [SW-1:0]        off_d   [LANES];
    logic [SW-1:0]        tap_q   [LANES];
    logic [SW-1:0]        tap_new [LANES];
    logic [SW-1:0]        tap_sel [LANES];
    logic [SW-1:0]        last_off;
    logic [DW-1:0]        lane_out [LANES];
    logic [LANES*DW-1:0]  aligned_word;
    logic                 enter_stream, load_word;

    // The lane count follows cfg_lanes only while idle; a packet keeps its mask.
    assign cfg_mask_full = lane_mask(cfg_lanes, LANES);
    assign cfg_mask      = cfg_mask_full[LANES-1:0];
    assign cur_mask      = (state_q == ST_IDLE) ? cfg_mask : mask_q;

    // Packet start is the rising edge of "any active lane valid".
    assign valid_any = |(byte_valid & cur_mask);
    assign start     = valid_any & ~valid_any_q;
    assign new_lanes = byte_valid & cur_mask & ~arrived_q;
    assign cnt_inc   = cnt_q + SW'(1);

    // Next-state, arrival tracking and the timeout pulse.
    // err_skew is decoded here so the pulse lands in the deadline cycle itself.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        arrived_d = arrived_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        err_skew  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    arrived_d = byte_valid & cur_mask;
                    for (int i = 0; i < LANES; i++) off_d[i] = '0;
                    cnt_d   = '0;
                    state_d = (arrived_d == cur_mask) ? ST_STREAM : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                cnt_d = cnt_inc;
                for (int i = 0; i < LANES; i++) begin
                    if (new_lanes[i]) off_d[i] = cnt_inc;
                end
                arrived_d = arrived_q | new_lanes;
                if (packet_done) begin
                    state_d = ST_IDLE;
                end else if (arrived_d == cur_mask) begin
                    state_d = ST_STREAM;
                end else if (cnt_inc == SW'(MAX_SKEW)) begin
                    err_skew = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (packet_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_stream = (state_q != ST_STREAM) && (state_d == ST_STREAM);
    assign load_word    = (state_q == ST_STREAM) || enter_stream;

    // Taps from the latest lane's offset; the entry cycle uses them before they are registered.
    always_comb begin
        last_off = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cur_mask[i] && (off_d[i] > last_off)) last_off = off_d[i];
        end
        for (int i = 0; i < LANES; i++) begin
            tap_new[i] = cur_mask[i] ? (last_off - off_d[i]) : '0;
            tap_sel[i] = enter_stream ? tap_new[i] : tap_q[i];
        end
    end

    // Per-lane delay lines, inactive-lane zeroing and tap status.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_delay_line #(
            .DW    (DW),
            .DEPTH (MAX_SKEW),
            .SW    (SW)
        ) u_dly (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .din     (byte_data[g*DW +: DW]),
            .tap     (tap_sel[g]),
            .dout    (lane_out[g])
        );
        assign aligned_word[g*DW +: DW] = cur_mask[g] ? lane_out[g] : '0;
        assign skew_tap[g*SW +: SW]     = tap_q[g];
    end

    // Control state: FSM, lane mask, start edge detector, arrival and offset capture.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            valid_any_q <= 1'b0;
            arrived_q   <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < LANES; i++) off_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= cur_mask;
            valid_any_q <= valid_any;
            arrived_q   <= arrived_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
        end
    end

    // Output registers: word stream, valid flag and applied taps (held until the next start).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) tap_q[i] <= '0;
        end else begin
            word_valid <= (state_d == ST_STREAM);
            if (load_word) word_data <= aligned_word;
            if (enter_stream) begin
                tap_q <= tap_new;
            end else if ((state_q == ST_IDLE) && start) begin
                for (int i = 0; i < LANES; i++) tap_q[i] <= '0;
            end
        end
    end

endmodule
